// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper move controller: FSM states,
// motor drive encodings and acceleration-ramp constants.
package stepper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STEP   = 2'd2,
      ST_FINISH = 2'd3
   } state_e;

   localparam logic [1:0] MOTOR_HOLD = 2'b00;
   localparam logic [1:0] MOTOR_FWD  = 2'b01;
   localparam logic [1:0] MOTOR_REV  = 2'b10;

   // Intervals shorter than this would leave no WAIT cycle between pulses.
   localparam int unsigned MIN_PERIOD = 2;

   // Ramp spans RAMP_LEN steps at each end; increment is period >> shift.
   localparam int unsigned RAMP_LEN       = 8;
   localparam int unsigned RAMP_INC_SHIFT = 2;

endpackage

// File: rtl/stepper_interval_timer.sv
// Step interval down-counter. A load sets the count; while enabled it
// decrements towards zero. expire flags the last cycle of the interval
// (count == 1) so the owner can act on the following edge.
module stepper_interval_timer #(
   parameter int CNT_W = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             count_en,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_r;

   // Counter register: load has priority over counting; holds at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (count_en && (cnt_r != '0)) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/stepper_move_ctrl.sv
// Stepper move controller: accepts a move command (steps, direction,
// period), emits one-cycle step pulses on motor_cmd, tracks a signed
// position and reports completion through done/aborted.
// Optional build macro STEPPER_RAMP_EN adds a symmetric acceleration /
// deceleration ramp on the step intervals.
module stepper_move_ctrl
   import stepper_pkg::*;
#(
   parameter int STEP_W   = 16,
   parameter int PERIOD_W = 16,
   parameter int POS_W    = 24
) (
   input  logic                system1000,
   input  logic                system1000_rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [STEP_W-1:0]   cmd_steps,
   input  logic                cmd_dir,
   input  logic [PERIOD_W-1:0] cmd_period,
   input  logic                abort,
   output logic [1:0]          motor_cmd,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic [POS_W-1:0]    position
);

   // Two extra bits hold the ramped interval (up to 3x the period).
   localparam int CNT_W = PERIOD_W + 2;

   state_e              state_r;
   state_e              state_s;
   logic                dir_r;
   logic [PERIOD_W-1:0] period_r;
   logic [STEP_W-1:0]   remaining_r;
   logic [PERIOD_W-1:0] period_clamped_s;
   logic [PERIOD_W-1:0] per_s;
   logic                accept_s;
   logic                step_s;
   logic                abort_end_s;
   logic                load_s;
   logic [CNT_W-1:0]    load_val_s;
   logic                expire_s;
   logic                count_en_s;

`ifdef STEPPER_RAMP_EN
   logic [STEP_W-1:0]   issued_r;
   logic [STEP_W-1:0]   iss_s;
   logic [STEP_W-1:0]   rem_s;

   // Interval for the next step given steps already issued and steps left;
   // d measures distance from the nearer end of the move.
   function automatic logic [CNT_W-1:0] ramp_interval(
      input logic [PERIOD_W-1:0] per,
      input logic [STEP_W-1:0]   issued,
      input logic [STEP_W-1:0]   remaining
   );
      logic [STEP_W-1:0]   rem_m1;
      logic [STEP_W-1:0]   d;
      logic [PERIOD_W-1:0] inc;
      rem_m1 = remaining - STEP_W'(1);
      d      = (rem_m1 < issued) ? rem_m1 : issued;
      inc    = per >> RAMP_INC_SHIFT;
      if (d < STEP_W'(RAMP_LEN)) begin
         ramp_interval = CNT_W'(per) + CNT_W'(inc) * (CNT_W'(RAMP_LEN) - CNT_W'(d));
      end else begin
         ramp_interval = CNT_W'(per);
      end
   endfunction
`endif

   assign period_clamped_s = (cmd_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : cmd_period;
   assign count_en_s       = (state_r == ST_WAIT) || (state_r == ST_STEP);

   stepper_interval_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (system1000),
      .rst      (system1000_rst),
      .load     (load_s),
      .load_val (load_val_s),
      .count_en (count_en_s),
      .expire   (expire_s)
   );

   // Next-state logic plus interval reload on acceptance and on each step.
   always_comb begin
      state_s     = state_r;
      accept_s    = 1'b0;
      step_s      = 1'b0;
      abort_end_s = 1'b0;
      load_s      = 1'b0;
      per_s       = period_r;
      load_val_s  = '0;
`ifdef STEPPER_RAMP_EN
      iss_s       = '0;
      rem_s       = '0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept_s = 1'b1;
               if (cmd_steps == '0) begin
                  state_s = ST_FINISH;
               end else begin
                  state_s = ST_WAIT;
                  load_s  = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_s     = ST_FINISH;
               abort_end_s = 1'b1;
            end else if (expire_s) begin
               state_s = ST_STEP;
               step_s  = 1'b1;
               load_s  = 1'b1;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_STEP: begin
            if (abort) begin
               state_s     = ST_FINISH;
               abort_end_s = 1'b1;
            end else if (remaining_r == '0) begin
               state_s = ST_FINISH;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_FINISH: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      if (accept_s) begin
         per_s = period_clamped_s;
`ifdef STEPPER_RAMP_EN
         iss_s = '0;
         rem_s = cmd_steps;
`endif
      end else begin
         per_s = period_r;
`ifdef STEPPER_RAMP_EN
         iss_s = issued_r + STEP_W'(1);
         rem_s = remaining_r - STEP_W'(1);
`endif
      end

`ifdef STEPPER_RAMP_EN
      load_val_s = ramp_interval(per_s, iss_s, rem_s);
`else
      load_val_s = CNT_W'(per_s);
`endif
   end

   // State register and registered outputs decoded from the next state.
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         state_r   <= ST_IDLE;
         cmd_ready <= 1'b1;
         motor_cmd <= MOTOR_HOLD;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         state_r   <= state_s;
         cmd_ready <= (state_s == ST_IDLE);
         motor_cmd <= (state_s == ST_STEP) ? (dir_r ? MOTOR_REV : MOTOR_FWD) : MOTOR_HOLD;
         busy      <= (state_s != ST_IDLE);
         done      <= (state_s == ST_FINISH);
         aborted   <= abort_end_s;
      end
   end

   // Command latch, step bookkeeping and position tracking.
   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         dir_r       <= 1'b0;
         period_r    <= '0;
         remaining_r <= '0;
         position    <= '0;
`ifdef STEPPER_RAMP_EN
         issued_r    <= '0;
`endif
      end else if (accept_s) begin
         dir_r       <= cmd_dir;
         period_r    <= period_clamped_s;
         remaining_r <= cmd_steps;
`ifdef STEPPER_RAMP_EN
         issued_r    <= '0;
`endif
      end else if (step_s) begin
         remaining_r <= remaining_r - STEP_W'(1);
         position    <= dir_r ? (position - POS_W'(1)) : (position + POS_W'(1));
`ifdef STEPPER_RAMP_EN
         issued_r    <= issued_r + STEP_W'(1);
`endif
      end else begin
         dir_r       <= dir_r;
      end
   end

endmodule

// File: doc/stepper_move_ctrl.md
STEPPER_MOVE_CTRL -- requirements
Module: stepper_move_ctrl

Interface
REQ-001 SHALL have parameter STEP_W, default 16, width of the step count.
REQ-002 SHALL have parameter PERIOD_W, default 16, width of the step interval in clock cycles.
REQ-003 SHALL have parameter POS_W, default 24, width of the signed position counter.
REQ-004 SHALL have port system1000  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port system1000_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  move command offered.
REQ-007 SHALL have port cmd_ready  output  1  controller accepts a command.
REQ-008 SHALL have port cmd_steps  input  STEP_W  number of steps to issue.
REQ-009 SHALL have port cmd_dir  input  1  direction: 0 forward, 1 reverse.
REQ-010 SHALL have port cmd_period  input  PERIOD_W  cycles between steps.
REQ-011 SHALL have port abort  input  1  terminate the current move.
REQ-012 SHALL have port motor_cmd  output  2  stepper drive command: 00 hold, 01 step forward, 10 step reverse; 11 never driven.
REQ-013 SHALL have port busy  output  1  move in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at move end.
REQ-015 SHALL have port aborted  output  1  qualifies done: move ended by abort.
REQ-016 SHALL have port position  output  POS_W  signed step position.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> STEP -> (WAIT | FINISH) -> IDLE.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on the edge where cmd_valid&&cmd_ready.
REQ-019 SHALL latch cmd_steps, cmd_dir and cmd_period on acceptance; later input changes have no effect on the move.
REQ-020 SHALL clamp a latched cmd_period below 2 to 2.
REQ-021 SHALL assert motor_cmd (01/10 per direction) for exactly one cycle per step, in STEP, and 00 in all other states.
REQ-022 SHALL assert the first step pulse exactly interval cycles after the acceptance edge, and subsequent pulses exactly interval cycles apart.
REQ-023 SHALL enter FINISH after the final step pulse, pulse done for one cycle with aborted=0, and return to IDLE on the next cycle.
REQ-024 SHALL treat cmd_steps=0 as an empty move: FINISH on the cycle after acceptance, no step pulse.
REQ-025 SHALL update position by +1 (forward) or -1 (reverse) on the cycle each step pulse is driven, wrapping modulo 2^POS_W.
REQ-026 SHALL, on abort in WAIT or STEP, suppress any step due that cycle, go to FINISH, then pulse done with aborted=1.
REQ-027 SHALL ignore abort in IDLE and in FINISH.
REQ-028 SHALL drive busy=1 in WAIT, STEP and FINISH.

Reset
REQ-029 SHALL, on system1000_rst, enter IDLE with motor_cmd=00, busy=0, done=0, aborted=0, position=0 and cmd_ready=1 on the following cycle.
REQ-030 SHALL give reset priority over the command handshake and abort; reset mid-move discards the move without a done pulse.

Configuration
REQ-031 SHALL, with macro STEPPER_RAMP_EN defined, compute each step interval as cmd_period + RAMP_INC*(RAMP_LEN-d) when d<RAMP_LEN, else cmd_period. Here d=min(steps issued, steps remaining-1), RAMP_LEN=8 and RAMP_INC=cmd_period/4, truncated.
REQ-032 SHALL, without STEPPER_RAMP_EN, use interval=cmd_period for every step, with no ramp logic present.

Structure
REQ-033 SHALL place the FSM state enum, motor_cmd encodings, RAMP_LEN and the RAMP_INC shift in shared package stepper_pkg.
REQ-034 SHALL isolate the interval down-counter as sub-module stepper_interval_timer (load, count, expire).

Verification
REQ-035 SHALL verify basic move: steps=3, dir=0, period=5 -> motor_cmd=01 at 5, 10 and 15 cycles after acceptance; done at cycle 16; position=3.
REQ-036 SHALL verify reverse with wrap: position=0, steps=2, dir=1, period=2 -> two 10 pulses 2 cycles apart; position=0xFFFFFE.
REQ-037 SHALL verify zero and clamp: steps=0 -> done on the next cycle with no pulse; period=0 with steps=2 -> pulses 2 cycles apart.
REQ-038 SHALL verify abort: steps=10, period=4, abort held on the third pulse's due cycle -> no third pulse, done=1 with aborted=1, position=2.
REQ-039 SHALL verify handshake and reset: cmd_valid held while busy is not accepted until IDLE; reset mid-WAIT -> motor_cmd=00, no done, position=0.
REQ-040 SHALL verify ramp (STEPPER_RAMP_EN): steps=20, period=8 -> first interval 24, intervals shrink by 2 to 8, and are symmetric at the end.
